// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - sequential ALU stage: single-cycle ADD/SUB, bit-serial SLL
// start/busy/done handshake; results are held in registers until the next operation completes.
module multicycle_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_DONE;
          unique case (ALU_Operation_i)
            OP_ADD: result_d = A_i + B_i;
            OP_SUB: result_d = A_i - B_i;
            OP_SLL: begin
              acc_d = A_i;
              cnt_d = B_i[SHAMT_WIDTH-1:0];
              // A zero shift amount completes immediately with the unshifted source.
              if (B_i[SHAMT_WIDTH-1:0] == '0) result_d = A_i;
              else                            state_d  = S_SHIFT;
            end
            default: result_d = '0;
          endcase
          if (state_d == S_DONE) zero_d = (result_d == '0);
        end
      end
      S_SHIFT: begin
        acc_d = acc_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(SHAMT_WIDTH-1){1'b0}}, 1'b1}) begin
          result_d = acc_q << 1;
          zero_d   = ((acc_q << 1) == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign ALU_Result_o = result_q;
  assign Zero_o       = zero_q;

endmodule
